// File: rtl/if_stage_pkg.sv
// Shared definitions for the fetch stage and the pipeline registers built on it:
// opcode constants, the bubble word and the fetch-state encoding.
package if_stage_pkg;

    localparam logic [5:0]  OP_RTYPE = 6'b000000;
    localparam logic [5:0]  OP_LW    = 6'b100011;
    localparam logic [5:0]  OP_SW    = 6'b101011;
    localparam logic [5:0]  OP_BEQ   = 6'b000100;
    localparam logic [5:0]  OP_HALT  = 6'b111111;

    // All-zero word decodes as an R-type write to r0, so it is a safe bubble.
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble, load captures a new entry,
// otherwise the entry holds. Flush wins over load.
module if_id_reg
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] next_instr,
    input  logic [31:0] next_pc,
    output logic [31:0] instruction,
    output logic [31:0] entry_pc,
    output logic        valid
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instruction <= NOP_WORD;
            entry_pc    <= 32'h0;
            valid       <= 1'b0;
        end else if (flush) begin
            instruction <= NOP_WORD;
            entry_pc    <= 32'h0;
            valid       <= 1'b0;
        end else if (load) begin
            instruction <= next_instr;
            entry_pc    <= next_pc;
            valid       <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, the fetch FSM and the IF/ID register.
//   state   | meaning
//   ST_BOOT | one idle cycle after reset, nothing loaded
//   ST_RUN  | fetching; stall > branch flush > normal fetch
//   ST_HALT | halt opcode fetched; pc frozen, IF/ID fed bubbles
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          IMEM_AW     = 10,
    parameter logic [5:0]  HALT_OPCODE = OP_HALT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               beq_taken,
    input  logic [31:0]        beq_imm,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        instruction,
    output logic [31:0]        if_pc,
    output logic               if_valid,
    output logic [31:0]        pc,
    output logic               halted,
    output logic [31:0]        fetch_count
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc_nxt;
    logic [31:0]  count_nxt;
    logic [31:0]  br_sum;
    logic         ifid_load;
    logic         ifid_flush;
    logic         is_halt_word;

    // Branch offset is relative to the branch's own PC + 4, counted in words.
    assign br_sum       = if_pc + 32'd4 + (beq_imm << 2);
    assign is_halt_word = (imem_rdata[31:26] == HALT_OPCODE);
    assign imem_addr    = pc[IMEM_AW+1:2];
    assign halted       = (state == ST_HALT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_BOOT;
            pc          <= RESET_PC;
            fetch_count <= 32'h0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            fetch_count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        count_nxt  = fetch_count;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        unique case (state)
            ST_BOOT: begin
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!stall) begin
                    if (beq_taken) begin
                        pc_nxt     = br_sum & ~32'd3;
                        ifid_flush = 1'b1;
                    end else begin
                        ifid_load = 1'b1;
                        count_nxt = fetch_count + 32'd1;
                        if (is_halt_word) begin
                            state_nxt = ST_HALT;
                        end else begin
                            pc_nxt = pc + 32'd4;
                        end
                    end
                end
            end
            ST_HALT: begin
                ifid_flush = !stall;
            end
            default: begin
                state_nxt = ST_BOOT;
            end
        endcase
    end

    if_id_reg u_if_id (
        .clk         (clk),
        .reset       (reset),
        .load        (ifid_load),
        .flush       (ifid_flush),
        .next_instr  (imem_rdata),
        .next_pc     (pc),
        .instruction (instruction),
        .entry_pc    (if_pc),
        .valid       (if_valid)
    );

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: vector tables for the fetch/stall/branch/halt
// sequences, a queue of expected IF/ID words, and a hand-written async-reset check.
module tb_if_stage;

    localparam int IMEM_AW = 10;
    localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

    logic               clk;
    logic               reset;
    logic               stall;
    logic               beq_taken;
    logic [31:0]        beq_imm;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic [31:0]        instruction;
    logic [31:0]        if_pc;
    logic               if_valid;
    logic [31:0]        pc;
    logic               halted;
    logic [31:0]        fetch_count;

    logic [31:0] mem [0:(1<<IMEM_AW)-1];

    int total;
    int bad;

    typedef struct {
        logic        stall;
        logic        beq;
        logic [31:0] imm;
        logic [31:0] exp_pc;
        logic [31:0] exp_ip;
        logic        exp_v;
        logic        exp_h;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t        tbl_a [$];
    vec_t        tbl_b [$];
    logic [31:0] sb [$];

    if_stage #(
        .RESET_PC    (32'h0000_0000),
        .IMEM_AW     (IMEM_AW),
        .HALT_OPCODE (6'b111111)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .beq_taken   (beq_taken),
        .beq_imm     (beq_imm),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .if_pc       (if_pc),
        .if_valid    (if_valid),
        .pc          (pc),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    assign imem_rdata = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t t, input int idx);
        logic [31:0] exp_instr;
        logic [31:0] ip_word;
        stall     = t.stall;
        beq_taken = t.beq;
        beq_imm   = t.imm;
        ip_word   = t.exp_ip >> 2;
        sb.push_back(t.exp_v ? mem[ip_word[IMEM_AW-1:0]] : 32'h0);
        @(posedge clk);
        #1;
        exp_instr = sb.pop_front();
        chk($sformatf("v%0d_pc", idx), pc, t.exp_pc);
        chk($sformatf("v%0d_if_pc", idx), if_pc, t.exp_ip);
        chk($sformatf("v%0d_valid", idx), {31'h0, if_valid}, {31'h0, t.exp_v});
        chk($sformatf("v%0d_halted", idx), {31'h0, halted}, {31'h0, t.exp_h});
        chk($sformatf("v%0d_count", idx), fetch_count, t.exp_cnt);
        chk($sformatf("v%0d_instr", idx), instruction, exp_instr);
        chk($sformatf("v%0d_imem_addr", idx), {22'h0, imem_addr}, {22'h0, t.exp_pc[IMEM_AW+1:2]});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < (1 << IMEM_AW); i++) mem[i] = 32'h1000_0000 + i;
        mem[0] = 32'd11;
        mem[1] = 32'd22;
        mem[2] = 32'd33;
        mem[3] = 32'd44;
        mem[4] = HALT_WORD | 32'h10;
        mem[8] = HALT_WORD | 32'h20;

        // Branch/flush run, ending at pc=0x40 for the async reset check.
        //              stall beq  imm    pc      if_pc  v     h     count
        tbl_b.push_back('{1'b0, 1'b0, 32'd0, 32'd0,  32'd0,  1'b0, 1'b0, 32'd0});
        tbl_b.push_back('{1'b0, 1'b0, 32'd0, 32'd4,  32'd0,  1'b1, 1'b0, 32'd1});
        tbl_b.push_back('{1'b0, 1'b0, 32'd0, 32'd8,  32'd4,  1'b1, 1'b0, 32'd2});
        tbl_b.push_back('{1'b0, 1'b0, 32'd0, 32'd12, 32'd8,  1'b1, 1'b0, 32'd3});
        tbl_b.push_back('{1'b0, 1'b1, 32'd3, 32'd24, 32'd0,  1'b0, 1'b0, 32'd3});
        tbl_b.push_back('{1'b0, 1'b0, 32'd0, 32'd28, 32'd24, 1'b1, 1'b0, 32'd4});
        tbl_b.push_back('{1'b0, 1'b0, 32'd0, 32'd32, 32'd28, 1'b1, 1'b0, 32'd5});
        // pc=32 holds a halt word; flushing it must not halt.
        tbl_b.push_back('{1'b0, 1'b1, 32'd5, 32'd52, 32'd0,  1'b0, 1'b0, 32'd5});
        tbl_b.push_back('{1'b0, 1'b0, 32'd0, 32'd56, 32'd52, 1'b1, 1'b0, 32'd6});
        tbl_b.push_back('{1'b0, 1'b0, 32'd0, 32'd60, 32'd56, 1'b1, 1'b0, 32'd7});
        tbl_b.push_back('{1'b0, 1'b0, 32'd0, 32'd64, 32'd60, 1'b1, 1'b0, 32'd8});

        // Restart after reset: BOOT ignores stall/branch, stall holds, halt at 16.
        tbl_a.push_back('{1'b1, 1'b1, 32'd5, 32'd0,  32'd0,  1'b0, 1'b0, 32'd0});
        tbl_a.push_back('{1'b0, 1'b0, 32'd0, 32'd4,  32'd0,  1'b1, 1'b0, 32'd1});
        tbl_a.push_back('{1'b0, 1'b0, 32'd0, 32'd8,  32'd4,  1'b1, 1'b0, 32'd2});
        tbl_a.push_back('{1'b0, 1'b0, 32'd0, 32'd12, 32'd8,  1'b1, 1'b0, 32'd3});
        tbl_a.push_back('{1'b1, 1'b0, 32'd0, 32'd12, 32'd8,  1'b1, 1'b0, 32'd3});
        tbl_a.push_back('{1'b1, 1'b1, 32'd3, 32'd12, 32'd8,  1'b1, 1'b0, 32'd3});
        tbl_a.push_back('{1'b0, 1'b0, 32'd0, 32'd16, 32'd12, 1'b1, 1'b0, 32'd4});
        tbl_a.push_back('{1'b0, 1'b0, 32'd0, 32'd16, 32'd16, 1'b1, 1'b1, 32'd5});
        tbl_a.push_back('{1'b0, 1'b1, 32'd7, 32'd16, 32'd0,  1'b0, 1'b1, 32'd5});
        tbl_a.push_back('{1'b1, 1'b0, 32'd0, 32'd16, 32'd0,  1'b0, 1'b1, 32'd5});
        tbl_a.push_back('{1'b0, 1'b0, 32'd0, 32'd16, 32'd0,  1'b0, 1'b1, 32'd5});

        reset     = 1'b0;
        stall     = 1'b0;
        beq_taken = 1'b0;
        beq_imm   = 32'h0;
        @(posedge clk);
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);
        chk("rst_count", fetch_count, 32'h0);
        chk("rst_instr", instruction, 32'h0);
        reset = 1'b1;

        foreach (tbl_b[i]) run_vec(tbl_b[i], i);

        // Mid-run reset must take effect without a clock edge.
        reset = 1'b0;
        #2;
        chk("async_pc", pc, 32'h0);
        chk("async_valid", {31'h0, if_valid}, 32'h0);
        chk("async_if_pc", if_pc, 32'h0);
        chk("async_count", fetch_count, 32'h0);
        chk("async_halted", {31'h0, halted}, 32'h0);
        #1;
        reset = 1'b1;

        foreach (tbl_a[i]) run_vec(tbl_a[i], 100 + i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
